cam_pixel_packer: RTL and testbench
===================================

// Module: cam_pixel_packer
// PURPOSE
//  Camera-side capture front end, in the clk domain. Synchronises raw OV7670 pins (pclk, vsync, href, d[7:0]).
//  Pairs RGB565 byte pairs into one pixel and reduces each pixel to RGB332.
//  Writes one frame into the frame-buffer RAM: one write per pixel, at a linear address.
//  Replaces the capture counter that currently runs directly on the camera pclk.
// PARAMETERS
//  H_PIXELS    640   pixels per line; each pixel is 2 bytes on the bus
//  V_LINES     480   lines per frame
//  ADDR_W      19    frame-buffer address width; 2**ADDR_W must be >= H_PIXELS*V_LINES
//  SYNC_STAGES 2     flip-flop stages on every camera input; must be >= 2
// PORTS
//  clk            in   1       system clock; must run at >= 4x cam_pclk (100 MHz vs 25 MHz)
//  rst            in   1       synchronous reset, active-high
//  cam_pclk       in   1       camera pixel clock, asynchronous; sampled as data
//  cam_vsync      in   1       camera frame sync; high = vertical blank
//  cam_href       in   1       camera line valid
//  cam_data       in   8       camera byte bus
//  cap_start      in   1       1-clk pulse: arm a capture
//  cap_continuous in   1       1 = re-arm automatically after each frame
//  fb_we          out  1       frame-buffer write strobe, 1 clk wide
//  fb_addr        out  ADDR_W  write address
//  fb_data        out  8       RGB332 pixel {R[4:2],G[5:3],B[4:3]}
//  busy           out  1       high in WAIT_VS, SYNC and CAPTURE
//  frame_done     out  1       1-clk pulse at the end of each captured frame
//  err_odd_byte   out  1       sticky: href fell with half a pixel pending
//  err_overflow   out  1       sticky: more than H_PIXELS*V_LINES pixels arrived in one frame
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; byte phase = 0; address = 0; sticky errors cleared.
//  Input synchronisation:
//   - pclk, vsync, href and data all pass through SYNC_STAGES flops, so they stay aligned with each other.
//   - A pclk rising edge is detected when the synced pclk is 1 and its previous value was 0.
//     That edge samples the synced href and data.
//  Byte pairing (on each pclk edge with href=1):
//   - phase 0: hold byte as hi = {R[4:0],G[5:3]}; set phase to 1.
//   - phase 1: lo = {G[2:0],B[4:0]}; form the pixel; set phase to 0.
//  Write latency: fb_we/fb_data/fb_addr are registered. fb_we is high exactly 1 clk after the clk where the phase-1 edge is detected.
//  fb_addr on each write is the current pixel index. The index increments after each write.
//  FSM states:
//   - IDLE:    cap_start moves to WAIT_VS.
//   - WAIT_VS: wait for synced vsync = 1; then move to SYNC. This rejects a frame already in progress.
//   - SYNC:    on a vsync falling edge, clear address and phase, then move to CAPTURE.
//   - CAPTURE: write pixels. A vsync rising edge ends the frame: frame_done pulses 1 clk, then go to
//              WAIT_VS if cap_continuous=1, else IDLE.
//  Boundary conditions:
//   - href falls while phase=1: set err_odd_byte, drop the half byte, reset phase to 0. The address does not advance.
//   - address reaches H_PIXELS*V_LINES: further pixels are not written (fb_we stays 0) and err_overflow is set.
//     The address saturates at H_PIXELS*V_LINES.
//   - Short frame (vsync rises early): frame_done still pulses; unwritten locations are left untouched.
//   - cap_start outside IDLE: ignored.
//   - cap_start in the same clk as frame end: ignored, because the FSM is not in IDLE that cycle.
//   - Sticky errors clear only on rst or on cap_start accepted in IDLE.
//   - rst mid-frame: the FSM returns to IDLE in the next clk and any in-flight write is cancelled (fb_we=0).
//  No back-pressure: the RAM accepts one write per clk, and writes are at most 1 per 8 clk.
// STRUCTURE
//  Shared package cam_pkg:
//   - FSM state encoding {IDLE, WAIT_VS, SYNC, CAPTURE}
//   - RGB565 to RGB332 field-slice constants
//   - default H_PIXELS/V_LINES
//  Sub-module cam_in_sync: SYNC_STAGES flops on {pclk,vsync,href,data}, plus the pclk rise and vsync rise/fall edge strobes.
//  Top level holds the FSM, byte pairing, address counter and error flags.
// TESTING
//  1. Camera model at 25 MHz, 4x2 frame (H_PIXELS=4, V_LINES=2), cap_start once.
//     Bytes 0xF8,0x00 give pixel 0xE0; bytes 0x07,0xE0 give 0x1C; bytes 0x00,0x1F give 0x03.
//     -> 8 writes at addr 0..7 with those values; frame_done 1 pulse; FSM returns to IDLE.
//  2. cap_start in the middle of a frame -> no write until the next vsync 1->0; the first write goes to addr 0.
//  3. Line with 7 bytes (odd) -> 3 writes for that line; err_odd_byte=1; next line starts at phase 0 with the correct address.
//  4. Frame with 9 pixels, H_PIXELS*V_LINES=8 -> exactly 8 writes; err_overflow=1; fb_addr never exceeds 8.
//  5. cap_continuous=1 over 3 frames -> 3 frame_done pulses; each frame writes from addr 0.
//  6. rst asserted mid-line -> fb_we=0 from the next clk; all outputs at reset values; no writes until a new cap_start.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture front end.
//  - cap_state_t : capture FSM state encoding
//  - RGB565 -> RGB332 field slices and the packing helper
//  - default frame geometry
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SYNC    = 2'd2,
    ST_CAPTURE = 2'd3
  } cap_state_t;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  // The camera sends RGB565 as hi = {R[4:0],G[5:3]}, lo = {G[2:0],B[4:0]}.
  // RGB332 keeps the top bits of each colour field:
  //   R[4:2] = hi[7:5], G[5:3] = hi[2:0], B[4:3] = lo[4:3].
  localparam int R_HI_MSB = 7;
  localparam int R_HI_LSB = 5;
  localparam int G_HI_MSB = 2;
  localparam int G_HI_LSB = 0;
  localparam int B_LO_MSB = 4;
  localparam int B_LO_LSB = 3;

  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[R_HI_MSB:R_HI_LSB], hi[G_HI_MSB:G_HI_LSB], lo[B_LO_MSB:B_LO_LSB]};
  endfunction

endpackage

// File: rtl/cam_pixel_packer_sync.sv
// Camera pin synchroniser.
// All camera pins share one SYNC_STAGES-deep chain so pclk, vsync, href and
// data stay mutually aligned after synchronisation.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   pclk_i .. data_i      raw asynchronous camera pins
//   vsync_s, href_s,
//   data_s                synchronised levels
//   pclk_rise             1-clk strobe on synced pclk 0->1
//   vsync_rise/_fall      1-clk strobes on synced vsync edges
//   href_fall             1-clk strobe on synced href 1->0
module cam_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_s,
  output logic       href_s,
  output logic [7:0] data_s,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  localparam int W = 11;

  logic [SYNC_STAGES-1:0][W-1:0] stage_q, stage_d;
  logic [2:0]                    prev_q, prev_d;   // {pclk, vsync, href} one clk ago
  logic                          pclk_s;

  assign {pclk_s, vsync_s, href_s, data_s} = stage_q[SYNC_STAGES-1];

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], {pclk_i, vsync_i, href_i, data_i}};
    prev_d  = {pclk_s, vsync_s, href_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign pclk_rise  =  pclk_s  & ~prev_q[2];
  assign vsync_rise =  vsync_s & ~prev_q[1];
  assign vsync_fall = ~vsync_s &  prev_q[1];
  assign href_fall  = ~href_s  &  prev_q[0];

endmodule

// File: rtl/cam_pixel_packer.sv
// OV7670 capture front end running entirely in the clk domain.
// Synchronises the camera pins, pairs RGB565 bytes into pixels, reduces them
// to RGB332 and writes one frame into the frame buffer at linear addresses.
// Ports:
//   clk, rst          system clock (>= 4x cam_pclk), synchronous active-high reset
//   cam_*             raw camera pins (pclk is sampled as data)
//   cap_start         1-clk pulse arming a capture (accepted only in IDLE)
//   cap_continuous    re-arm automatically after each frame
//   fb_we/addr/data   registered frame-buffer write port
//   busy              FSM outside IDLE
//   frame_done        1-clk pulse at the end of each captured frame
//   err_odd_byte      sticky: line ended with half a pixel pending
//   err_overflow      sticky: frame carried more than H_PIXELS*V_LINES pixels
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int ADDR_W      = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              cap_start,
  input  logic              cap_continuous,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_odd_byte,
  output logic              err_overflow
);

  // One extra bit so the saturated count can equal 2**ADDR_W.
  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_PIXELS * V_LINES);
  localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic       vsync_s, href_s;
  logic [7:0] data_s;
  logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

  cam_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .pclk_i     (cam_pclk),
    .vsync_i    (cam_vsync),
    .href_i     (cam_href),
    .data_i     (cam_data),
    .vsync_s    (vsync_s),
    .href_s     (href_s),
    .data_s     (data_s),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  cap_state_t        state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_odd_q, err_odd_d;
  logic              err_ovf_q, err_ovf_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    err_odd_d    = err_odd_q;
    err_ovf_d    = err_ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          state_d   = ST_WAIT_VS;
          err_odd_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end

      // Waiting for vertical blank first means a frame already on the bus
      // is never captured from its middle.
      ST_WAIT_VS: begin
        if (vsync_s) begin
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (vsync_fall) begin
          addr_d  = '0;
          phase_d = 1'b0;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (href_fall && phase_q) begin
          // Line ended mid-pixel: discard the stored hi byte.
          err_odd_d = 1'b1;
          phase_d   = 1'b0;
        end else if (pclk_rise && href_s) begin
          if (!phase_q) begin
            hi_d    = data_s;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (addr_q < PIX_TOTAL) begin
              fb_we_d   = 1'b1;
              fb_addr_d = addr_q[ADDR_W-1:0];
              fb_data_d = rgb565_to_332(hi_q, data_s);
              addr_d    = addr_q + ADDR_ONE;
            end else begin
              err_ovf_d = 1'b1;
            end
          end
        end

        if (vsync_rise) begin
          frame_done_d = 1'b1;
          state_d      = cap_continuous ? ST_WAIT_VS : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      addr_q       <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_odd_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      err_odd_q    <= err_odd_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign err_odd_byte = err_odd_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: 4x2 frame, 100 MHz clk, 25 MHz camera model.
module tb_cam_pixel_packer;

  localparam int HP    = 4;
  localparam int VL    = 2;
  localparam int AW    = 4;
  localparam int TOTAL = HP * VL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          cap_start = 1'b0;
  logic          cap_continuous = 1'b0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          busy, frame_done, err_odd_byte, err_overflow;

  cam_pixel_packer #(
    .H_PIXELS (HP), .V_LINES (VL), .ADDR_W (AW), .SYNC_STAGES (2)
  ) dut (
    .clk (clk), .rst (rst),
    .cam_pclk (cam_pclk), .cam_vsync (cam_vsync), .cam_href (cam_href), .cam_data (cam_data),
    .cap_start (cap_start), .cap_continuous (cap_continuous),
    .fb_we (fb_we), .fb_addr (fb_addr), .fb_data (fb_data),
    .busy (busy), .frame_done (frame_done),
    .err_odd_byte (err_odd_byte), .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor: records every write and frame_done pulse.
  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_data[$];
  int            fd_cnt = 0;
  int            wide_we = 0;
  logic          we_prev = 1'b0;

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_addr.push_back(fb_addr);
      wr_data.push_back(fb_data);
      if (we_prev) wide_we++;
    end
    we_prev = (fb_we === 1'b1);
    if (frame_done === 1'b1) fd_cnt++;
  end

  // Frame description and reference model.
  byte unsigned  frm_bytes[$];
  int            line_len[$];
  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_data[$];
  bit            exp_odd, exp_ovf;

  function automatic logic [7:0] ref_pixel(input int hi, input int lo);
    int r5, g6, b5;
    r5 = hi / 8;
    g6 = (hi % 8) * 8 + lo / 32;
    b5 = lo % 32;
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + b5 / 8);
  endfunction

  // Appends one frame's expected writes (addresses restart at 0 per frame).
  task automatic model_frame();
    int k = 0;
    int pix = 0;
    foreach (line_len[l]) begin
      for (int p = 0; p < line_len[l] / 2; p++) begin
        if (pix < TOTAL) begin
          exp_addr.push_back(AW'(pix));
          exp_data.push_back(ref_pixel(frm_bytes[k + 2*p], frm_bytes[k + 2*p + 1]));
        end else begin
          exp_ovf = 1'b1;
        end
        pix++;
      end
      if (line_len[l] % 2 != 0) exp_odd = 1'b1;
      k += line_len[l];
    end
  endtask

  task automatic make_frame(input int l0, input int l1);
    frm_bytes.delete();
    line_len.delete();
    line_len.push_back(l0);
    line_len.push_back(l1);
    for (int i = 0; i < l0 + l1; i++) frm_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_all();
    wr_addr.delete(); wr_data.delete();
    exp_addr.delete(); exp_data.delete();
    fd_cnt = 0; wide_we = 0; exp_odd = 0; exp_ovf = 0;
  endtask

  // One camera pclk period (4 clk): change pins with pclk low, then raise pclk.
  task automatic cam_clk(input logic hr, input logic vs, input logic [7:0] d);
    cam_pclk = 1'b0; cam_href = hr; cam_vsync = vs; cam_data = d;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_frame();
    int k = 0;
    repeat (3) cam_clk(1'b0, 1'b1, 8'h00);
    repeat (2) cam_clk(1'b0, 1'b0, 8'h00);
    foreach (line_len[l]) begin
      for (int b = 0; b < line_len[l]; b++) begin
        cam_clk(1'b1, 1'b0, frm_bytes[k]);
        k++;
      end
      repeat (2) cam_clk(1'b0, 1'b0, 8'h00);
    end
    repeat (3) cam_clk(1'b0, 1'b1, 8'h00);
  endtask

  task automatic pulse_start();
    @(negedge clk) cap_start = 1'b1;
    @(negedge clk) cap_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({fb_we, busy, frame_done, err_odd_byte, err_overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got we/busy/done/odd/ovf=%b, expected 00000",
               {fb_we, busy, frame_done, err_odd_byte, err_overflow});
    end
    checks++;
    if (fb_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", fb_addr); end
    checks++;
    if (fb_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 00", fb_data); end
    $display("test_reset: done");
  endtask

  task automatic test_basic_frame();
    byte unsigned fixed[6] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    clear_all();
    make_frame(8, 8);
    for (int i = 0; i < 6; i++) frm_bytes[i] = fixed[i];
    model_frame();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_armed: got %b, expected 1", busy); end
    drive_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL basic_count: got %0d writes, expected %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (fd_cnt != 1 || busy !== 1'b0 || wide_we != 0) begin
      errors++; $display("FAIL basic_end: got done=%0d busy=%b wide=%0d, expected 1 0 0", fd_cnt, busy, wide_we);
    end
    checks++;
    if ({err_odd_byte, err_overflow} !== 2'b00) begin
      errors++; $display("FAIL basic_errs: got %b, expected 00", {err_odd_byte, err_overflow});
    end
    $display("test_basic_frame: %0d writes, %0d frame_done", wr_addr.size(), fd_cnt);
  endtask

  task automatic test_mid_frame_start();
    clear_all();
    make_frame(8, 8);
    fork
      drive_frame();
      begin
        repeat (40) @(negedge clk);
        cap_start = 1'b1;
        @(negedge clk) cap_start = 1'b0;
      end
    join
    checks++;
    if (wr_addr.size() != 0) begin
      errors++; $display("FAIL midstart_partial: got %0d writes, expected 0", wr_addr.size());
    end
    make_frame(8, 8);
    model_frame();
    drive_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL midstart_count: got %0d writes, expected %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL midstart_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (fd_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL midstart_end: got done=%0d busy=%b, expected 1 0", fd_cnt, busy);
    end
    $display("test_mid_frame_start: %0d writes", wr_addr.size());
  endtask

  task automatic test_odd_byte();
    clear_all();
    make_frame(7, 8);
    model_frame();
    pulse_start();
    drive_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL odd_count: got %0d writes, expected %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL odd_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (err_odd_byte !== exp_odd || err_overflow !== exp_ovf) begin
      errors++; $display("FAIL odd_flags: got odd=%b ovf=%b, expected odd=%b ovf=%b",
                         err_odd_byte, err_overflow, exp_odd, exp_ovf);
    end
    $display("test_odd_byte: %0d writes odd=%b", wr_addr.size(), err_odd_byte);
  endtask

  task automatic test_overflow();
    clear_all();
    make_frame(8, 10);
    model_frame();
    pulse_start();
    // Sticky odd-byte flag from the previous frame must clear on the accepted start.
    checks++;
    if (err_odd_byte !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clear: got %b, expected 0", err_odd_byte); end
    drive_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL ovf_count: got %0d writes, expected %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL ovf_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (err_overflow !== exp_ovf || err_odd_byte !== exp_odd || fd_cnt != 1) begin
      errors++; $display("FAIL ovf_flags: got ovf=%b odd=%b done=%0d, expected ovf=%b odd=%b done=1",
                         err_overflow, err_odd_byte, fd_cnt, exp_ovf, exp_odd);
    end
    $display("test_overflow: %0d writes ovf=%b", wr_addr.size(), err_overflow);
  endtask

  task automatic test_continuous();
    clear_all();
    cap_continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      make_frame(8, 8);
      model_frame();
      drive_frame();
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL cont_count: got %0d writes, expected %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL cont_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (fd_cnt != 3 || busy !== 1'b1 || wide_we != 0) begin
      errors++; $display("FAIL cont_end: got done=%0d busy=%b wide=%0d, expected 3 1 0", fd_cnt, busy, wide_we);
    end
    $display("test_continuous: %0d writes, %0d frame_done", wr_addr.size(), fd_cnt);
  endtask

  task automatic test_rst_midline();
    clear_all();
    make_frame(8, 8);
    fork
      drive_frame();
      begin
        repeat (36 + $urandom_range(0, 7)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({fb_we, busy, frame_done, err_odd_byte, err_overflow} !== 5'b0) begin
          errors++;
          $display("FAIL rst_flags: got we/busy/done/odd/ovf=%b, expected 00000",
                   {fb_we, busy, frame_done, err_odd_byte, err_overflow});
        end
        checks++;
        if (fb_addr !== '0 || fb_data !== '0) begin
          errors++; $display("FAIL rst_port: got addr=%0d data=%h, expected 0 00", fb_addr, fb_data);
        end
        rst = 1'b0;
        cap_continuous = 1'b0;
        wr_addr.delete(); wr_data.delete(); fd_cnt = 0;
      end
    join
    make_frame(8, 8);
    drive_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != 0 || fd_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: got writes=%0d done=%0d busy=%b, expected 0 0 0",
                         wr_addr.size(), fd_cnt, busy);
    end
    $display("test_rst_midline: %0d writes after reset", wr_addr.size());
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mid_frame_start();
    test_odd_byte();
    test_overflow();
    test_continuous();
    test_rst_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
